// File: rtl/slow_clock_monitor_pkg.sv
// ----------------------------------------------------------------------------
// slow_clock_monitor_pkg
//   Shared definitions for the slow clock receive-side monitor.
//   - MEAS_W          : width of half-period measurements (same width the
//                       clock_divider uses for its terminal count)
//   - GOOD_W          : width of the consecutive-good-measurement counter
//   - monitor_state_t : monitor state encoding (2 bits)
//   - abs_diff        : unsigned absolute difference with no overflow
// ----------------------------------------------------------------------------
package slow_clock_monitor_pkg;

  localparam int MEAS_W = 30;
  localparam int GOOD_W = 4;

  typedef enum logic [1:0] {
    SEARCH  = 2'd0,
    MEASURE = 2'd1,
    LOCKED  = 2'd2,
    LOST    = 2'd3
  } monitor_state_t;

  // The larger operand is always the minuend, so the result never wraps.
  function automatic logic [MEAS_W-1:0] abs_diff(input logic [MEAS_W-1:0] a,
                                                 input logic [MEAS_W-1:0] b);
    return (a >= b) ? (a - b) : (b - a);
  endfunction

endpackage

// File: rtl/slow_clock_monitor_sync_edge_detect.sv
// ----------------------------------------------------------------------------
// slow_clock_monitor_sync_edge_detect
//   Brings an asynchronous level into the clock domain through a two-flop
//   synchronizer and flags every transition of the synchronized level.
//   Ports:
//     clock      in  1  sampling clock
//     reset      in  1  synchronous, active-high; clears every flop
//     async_in   in  1  level asynchronous to clock
//     edge_pulse out 1  high for one cycle after each rising or falling edge
// ----------------------------------------------------------------------------
module slow_clock_monitor_sync_edge_detect (
  input  logic clock,
  input  logic reset,
  input  logic async_in,
  output logic edge_pulse
);

  logic meta_q;
  logic sync_q;
  logic sync_q_d;

  // Two synchronizer stages followed by one history stage. The history flop
  // lets us compare the current synchronized level against the previous one.
  // Everything clears to 0, so an input already high at reset release shows
  // up as a single edge.
  always_ff @(posedge clock) begin
    if (reset) begin
      meta_q   <= 1'b0;
      sync_q   <= 1'b0;
      sync_q_d <= 1'b0;
    end else begin
      meta_q   <= async_in;
      sync_q   <= meta_q;
      sync_q_d <= sync_q;
    end
  end

  // Either polarity counts, so each half-period of the slow clock is framed.
  assign edge_pulse = sync_q ^ sync_q_d;

endmodule

// File: rtl/slow_clock_monitor.sv
// ----------------------------------------------------------------------------
// slow_clock_monitor
//   Checks the divided slow clock in the fast clock domain. Each half-period is
//   measured in fast cycles and compared against CLOCK_LIMIT+1 within
//   TOLERANCE. LOCK_COUNT consecutive good half-periods declare lock; no edge
//   for TIMEOUT_CYCLES cycles declares loss.
//   Ports:
//     clock       in   1   fast board clock
//     reset       in   1   synchronous, active-high
//     slow_in     in   1   divided clock under test (asynchronous)
//     half_period out  30  last measured half-period in fast cycles
//     meas_valid  out  1   one-cycle pulse when half_period updates
//     meas_good   out  1   qualifies meas_valid: measurement within tolerance
//     locked      out  1   high while locked
//     lost        out  1   high while the slow clock is considered lost
// ----------------------------------------------------------------------------
module slow_clock_monitor
  import slow_clock_monitor_pkg::*;
#(
  parameter int unsigned CLOCK_LIMIT    = 100000000 / 10,
  parameter int unsigned TOLERANCE      = 2,
  parameter int unsigned LOCK_COUNT     = 4,
  parameter int unsigned TIMEOUT_CYCLES = 4 * (CLOCK_LIMIT + 1)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              slow_in,
  output logic [MEAS_W-1:0] half_period,
  output logic              meas_valid,
  output logic              meas_good,
  output logic              locked,
  output logic              lost
);

  localparam logic [MEAS_W-1:0] CNT_ONE      = MEAS_W'(1);
  localparam logic [MEAS_W-1:0] CNT_MAX      = {MEAS_W{1'b1}};
  localparam logic [MEAS_W-1:0] EXPECTED     = MEAS_W'(CLOCK_LIMIT + 1);
  localparam logic [MEAS_W-1:0] TOL          = MEAS_W'(TOLERANCE);
  localparam logic [MEAS_W-1:0] TIMEOUT_LAST = MEAS_W'(TIMEOUT_CYCLES - 1);
  localparam logic [GOOD_W-1:0] GOOD_ONE     = GOOD_W'(1);
  localparam logic [GOOD_W-1:0] LOCK_TARGET  = GOOD_W'(LOCK_COUNT);

  monitor_state_t    state;
  logic [MEAS_W-1:0] cnt;
  logic [GOOD_W-1:0] good_cnt;
  logic              edge_pulse;
  logic [MEAS_W-1:0] meas_len;
  logic              in_tol;
  logic              timeout_hit;
  logic              measuring;

  slow_clock_monitor_sync_edge_detect u_sync_edge_detect (
    .clock      (clock),
    .reset      (reset),
    .async_in   (slow_in),
    .edge_pulse (edge_pulse)
  );

  // cnt holds the number of cycles since the last edge minus one, so the
  // interval ending on an edge is cnt+1. Saturation keeps a dead input from
  // ever wrapping back into a plausible-looking value.
  assign meas_len    = (cnt == CNT_MAX) ? CNT_MAX : (cnt + CNT_ONE);
  assign in_tol      = (abs_diff(meas_len, EXPECTED) <= TOL);
  // An edge arriving on the deadline cycle still counts as activity.
  assign timeout_hit = !edge_pulse && (cnt == TIMEOUT_LAST);
  // SEARCH and LOST have no valid start point, so their edges only restart.
  assign measuring   = edge_pulse && ((state == MEASURE) || (state == LOCKED));

  // Free-running interval counter, restarted by every edge.
  always_ff @(posedge clock) begin
    if (reset) begin
      cnt <= '0;
    end else if (edge_pulse) begin
      cnt <= '0;
    end else if (cnt != CNT_MAX) begin
      cnt <= cnt + CNT_ONE;
    end
  end

  // Measurement outputs update on the cycle after a framed edge. half_period
  // holds its last value between measurements and across loss.
  always_ff @(posedge clock) begin
    if (reset) begin
      half_period <= '0;
      meas_valid  <= 1'b0;
      meas_good   <= 1'b0;
    end else begin
      meas_valid <= measuring;
      meas_good  <= measuring && in_tol;
      if (measuring) begin
        half_period <= meas_len;
      end
    end
  end

  // Lock/loss state machine. locked and lost are registered alongside the
  // state so they change on the same cycle the state does. good_cnt tracks
  // the run of in-tolerance measurements and is cleared whenever the run is
  // broken or the state is left.
  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= SEARCH;
      good_cnt <= '0;
      locked   <= 1'b0;
      lost     <= 1'b0;
    end else begin
      unique case (state)
        SEARCH: begin
          if (edge_pulse) begin
            state    <= MEASURE;
            good_cnt <= '0;
          end else if (timeout_hit) begin
            state    <= LOST;
            lost     <= 1'b1;
            good_cnt <= '0;
          end
        end
        MEASURE: begin
          if (edge_pulse) begin
            if (!in_tol) begin
              good_cnt <= '0;
            end else if ((good_cnt + GOOD_ONE) == LOCK_TARGET) begin
              state    <= LOCKED;
              locked   <= 1'b1;
              good_cnt <= '0;
            end else begin
              good_cnt <= good_cnt + GOOD_ONE;
            end
          end else if (timeout_hit) begin
            state    <= LOST;
            lost     <= 1'b1;
            good_cnt <= '0;
          end
        end
        LOCKED: begin
          if (edge_pulse) begin
            if (!in_tol) begin
              state    <= MEASURE;
              locked   <= 1'b0;
              good_cnt <= '0;
            end else if (good_cnt != LOCK_TARGET) begin
              good_cnt <= good_cnt + GOOD_ONE;
            end
          end else if (timeout_hit) begin
            state    <= LOST;
            locked   <= 1'b0;
            lost     <= 1'b1;
            good_cnt <= '0;
          end
        end
        LOST: begin
          if (edge_pulse) begin
            state    <= MEASURE;
            lost     <= 1'b0;
            good_cnt <= '0;
          end
        end
        default: begin
          state    <= SEARCH;
          good_cnt <= '0;
          locked   <= 1'b0;
          lost     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_slow_clock_monitor.sv
// ----------------------------------------------------------------------------
// tb_slow_clock_monitor
//   Self-checking bench for slow_clock_monitor with CLOCK_LIMIT=100,
//   TOLERANCE=2, LOCK_COUNT=4, TIMEOUT_CYCLES=404. A timestamp-based reference
//   model predicts every output on every cycle; scenario tasks add fixed
//   expectations at the interesting moments.
// ----------------------------------------------------------------------------
module tb_slow_clock_monitor;

  localparam int EXP_HP  = 101;
  localparam int TOL     = 2;
  localparam int LOCKN   = 4;
  localparam int TIMEOUT = 404;

  logic        clock;
  logic        reset;
  logic        slow_in;
  logic [29:0] half_period;
  logic        meas_valid;
  logic        meas_good;
  logic        locked;
  logic        lost;

  int tests    = 0;
  int failures = 0;

  slow_clock_monitor #(
    .CLOCK_LIMIT    (100),
    .TOLERANCE      (2),
    .LOCK_COUNT     (4),
    .TIMEOUT_CYCLES (404)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .slow_in     (slow_in),
    .half_period (half_period),
    .meas_valid  (meas_valid),
    .meas_good   (meas_good),
    .locked      (locked),
    .lost        (lost)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Reference model. slow_in is sampled on each rising edge; a change in the
  // sampled level shows up as a framed edge two samples later. Intervals are
  // differences of edge timestamps, and lock/loss follow from the run of
  // good intervals and the time since the last edge.
  int          cyc = 0;
  int          last_event = 0;
  int          span = 0;
  int          consec = 0;
  bit          have_ref = 0;
  bit          hist [4];
  logic [29:0] m_hp = '0;
  logic        m_valid = 0;
  logic        m_good = 0;
  logic        m_locked = 0;
  logic        m_lost = 0;

  always @(posedge clock) begin
    cyc++;
    if (reset) begin
      for (int i = 0; i < 4; i++) hist[i] = 1'b0;
      m_hp = '0; m_valid = 0; m_good = 0; m_locked = 0; m_lost = 0;
      have_ref = 0; consec = 0; last_event = cyc;
    end else begin
      hist[0] = hist[1]; hist[1] = hist[2]; hist[2] = hist[3]; hist[3] = slow_in;
      m_valid = 0;
      m_good  = 0;
      if (hist[1] != hist[0]) begin
        if (have_ref) begin
          span    = cyc - last_event;
          m_valid = 1;
          m_hp    = 30'(span);
          m_good  = (span >= EXP_HP - TOL) && (span <= EXP_HP + TOL);
          if (m_good) begin
            consec++;
            if (consec >= LOCKN) m_locked = 1;
          end else begin
            consec   = 0;
            m_locked = 0;
          end
        end else begin
          have_ref = 1;
          m_lost   = 0;
          consec   = 0;
        end
        last_event = cyc;
      end else if (!m_lost && (cyc - last_event == TIMEOUT)) begin
        m_lost = 1; m_locked = 0; have_ref = 0; consec = 0;
      end
    end
  end

  logic [33:0] obs;
  logic [33:0] exp_vec;
  assign obs     = {half_period, meas_valid, meas_good, locked, lost};
  assign exp_vec = {m_hp, m_valid, m_good, m_locked, m_lost};

  // Reset held for several cycles: everything reads zero.
  task automatic test_reset();
    reset   = 1'b1;
    slow_in = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(posedge clock); #1;
      tests++;
      if (obs !== 34'd0) begin
        failures++;
        $display("[TB] FAIL reset_state k=%0d got=%h want=%h", k, obs, 34'd0);
      end
    end
    reset = 1'b0;
  endtask

  // Clean 101-cycle half-periods from SEARCH: first edge only starts timing,
  // the fourth measurement brings locked up.
  task automatic test_lock();
    for (int p = 0; p < 5; p++) begin
      slow_in = ~slow_in;
      for (int k = 0; k < EXP_HP; k++) begin
        @(posedge clock); #1;
        tests++;
        if (obs !== exp_vec) begin
          failures++;
          $display("[TB] FAIL lock_model p=%0d k=%0d got=%h want=%h", p, k, obs, exp_vec);
        end
        if (k == 2) begin
          tests++;
          if ({meas_valid, meas_good, locked, half_period} !==
              {(p > 0), (p > 0), (p == 4), ((p > 0) ? 30'd101 : 30'd0)}) begin
            failures++;
            $display("[TB] FAIL lock_meas p=%0d got=%b%b%b hp=%0d want valid=%0d locked=%0d",
                     p, meas_valid, meas_good, locked, half_period, (p > 0), (p == 4));
          end
        end
      end
    end
  endtask

  // One long half-period breaks lock; four good ones restore it.
  task automatic test_relock();
    int lens [6] = '{104, 101, 101, 101, 101, 101};
    for (int p = 0; p < 6; p++) begin
      slow_in = ~slow_in;
      for (int k = 0; k < lens[p]; k++) begin
        @(posedge clock); #1;
        tests++;
        if (obs !== exp_vec) begin
          failures++;
          $display("[TB] FAIL relock_model p=%0d k=%0d got=%h want=%h", p, k, obs, exp_vec);
        end
        if (k == 2 && p > 0) begin
          tests++;
          if ({meas_valid, meas_good, locked, half_period} !==
              {1'b1, (p != 1), (p == 5), 30'(lens[p-1])}) begin
            failures++;
            $display("[TB] FAIL relock_meas p=%0d got=%b%b%b hp=%0d want good=%0d locked=%0d hp=%0d",
                     p, meas_valid, meas_good, locked, half_period, (p != 1), (p == 5), lens[p-1]);
          end
        end
      end
    end
  endtask

  // Tolerance boundaries: 99 and 103 are good, 98 and 104 are bad.
  task automatic test_tolerance();
    int lens [9] = '{99, 103, 98, 104, 101, 101, 101, 101, 101};
    for (int p = 0; p < 9; p++) begin
      slow_in = ~slow_in;
      for (int k = 0; k < lens[p]; k++) begin
        @(posedge clock); #1;
        tests++;
        if (obs !== exp_vec) begin
          failures++;
          $display("[TB] FAIL tol_model p=%0d k=%0d got=%h want=%h", p, k, obs, exp_vec);
        end
        if (k == 2 && p > 0) begin
          tests++;
          if ({meas_valid, meas_good, half_period} !==
              {1'b1, !(p == 3 || p == 4), 30'(lens[p-1])}) begin
            failures++;
            $display("[TB] FAIL tol_meas p=%0d got valid=%0d good=%0d hp=%0d want good=%0d hp=%0d",
                     p, meas_valid, meas_good, half_period, !(p == 3 || p == 4), lens[p-1]);
          end
        end
      end
    end
  endtask

  // Silence for 404 cycles after the last edge declares loss; the next edge
  // restarts without a measurement and the one after that measures again.
  task automatic test_timeout();
    int lens [3] = '{410, 101, 101};
    for (int p = 0; p < 3; p++) begin
      slow_in = ~slow_in;
      for (int k = 0; k < lens[p]; k++) begin
        @(posedge clock); #1;
        tests++;
        if (obs !== exp_vec) begin
          failures++;
          $display("[TB] FAIL timeout_model p=%0d k=%0d got=%h want=%h", p, k, obs, exp_vec);
        end
        if (p == 0 && (k == 405 || k == 406)) begin
          tests++;
          if ({lost, locked, half_period} !== {(k == 406), (k == 405), 30'd101}) begin
            failures++;
            $display("[TB] FAIL timeout_edge k=%0d got lost=%0d locked=%0d hp=%0d want lost=%0d locked=%0d hp=101",
                     k, lost, locked, half_period, (k == 406), (k == 405));
          end
        end
        if (p > 0 && k == 2) begin
          tests++;
          if ({lost, meas_valid} !== {1'b0, (p == 2)}) begin
            failures++;
            $display("[TB] FAIL timeout_restart p=%0d got lost=%0d valid=%0d want lost=0 valid=%0d",
                     p, lost, meas_valid, (p == 2));
          end
        end
      end
    end
  endtask

  // Lock, then pulse reset mid-half-period: outputs clear and the first
  // post-reset edge only restarts timing.
  task automatic test_reset_mid();
    int n = 6 + ((slow_in == 1'b0) ? 0 : 1);
    for (int p = 0; p < n; p++) begin
      slow_in = ~slow_in;
      for (int k = 0; k < ((p == n - 1) ? 50 : EXP_HP); k++) begin
        @(posedge clock); #1;
        tests++;
        if (obs !== exp_vec) begin
          failures++;
          $display("[TB] FAIL rstmid_model p=%0d k=%0d got=%h want=%h", p, k, obs, exp_vec);
        end
      end
    end
    tests++;
    if (locked !== 1'b1) begin
      failures++;
      $display("[TB] FAIL rstmid_prelock got=%0d want=1", locked);
    end
    slow_in = 1'b0;
    reset   = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    tests++;
    if (obs !== 34'd0) begin
      failures++;
      $display("[TB] FAIL rstmid_clear got=%h want=%h", obs, 34'd0);
    end
    for (int p = 0; p < 2; p++) begin
      slow_in = ~slow_in;
      for (int k = 0; k < EXP_HP; k++) begin
        @(posedge clock); #1;
        tests++;
        if (obs !== exp_vec || (p == 0 && meas_valid !== 1'b0) ||
            (p == 1 && k == 2 && {meas_valid, half_period} !== {1'b1, 30'd101})) begin
          failures++;
          $display("[TB] FAIL rstmid_after p=%0d k=%0d got=%h want=%h", p, k, obs, exp_vec);
        end
      end
    end
  endtask

  // slow_in stuck low from reset: SEARCH times out into LOST at cycle 404
  // and stays there while the counter sits saturated or keeps climbing.
  task automatic test_stuck();
    slow_in = 1'b0;
    reset   = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    for (int k = 1; k <= 900; k++) begin
      @(posedge clock); #1;
      tests++;
      if (obs !== exp_vec) begin
        failures++;
        $display("[TB] FAIL stuck_model k=%0d got=%h want=%h", k, obs, exp_vec);
      end
      if (k == 403 || k == 404 || k == 900) begin
        tests++;
        if ({lost, locked, meas_valid} !== {(k != 403), 1'b0, 1'b0}) begin
          failures++;
          $display("[TB] FAIL stuck_lost k=%0d got lost=%0d locked=%0d want lost=%0d",
                   k, lost, locked, (k != 403));
        end
      end
    end
  endtask

  // Random mix of near-nominal, deadline-straddling and glitch-short
  // half-periods, starting from a reset with a random input level.
  task automatic test_random();
    int len;
    int r;
    slow_in = 1'($urandom_range(0, 1));
    reset   = 1'b1;
    repeat (2) begin @(posedge clock); #1; end
    reset = 1'b0;
    for (int p = 0; p < 40; p++) begin
      r = int'($urandom_range(0, 9));
      if (r < 7)       len = int'($urandom_range(97, 105));
      else if (r == 7) len = int'($urandom_range(403, 405));
      else             len = int'($urandom_range(1, 20));
      slow_in = ~slow_in;
      for (int k = 0; k < len; k++) begin
        @(posedge clock); #1;
        tests++;
        if (obs !== exp_vec) begin
          failures++;
          $display("[TB] FAIL random_model p=%0d len=%0d k=%0d got=%h want=%h",
                   p, len, k, obs, exp_vec);
        end
      end
    end
  endtask

  initial begin
    reset   = 1'b1;
    slow_in = 1'b0;
    test_reset();
    test_lock();
    test_relock();
    test_tolerance();
    test_timeout();
    test_reset_mid();
    test_stuck();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("[TB] FAIL watchdog simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
